rangebin_fifo_in: RTL



---
 rtl/rangebin_fifo_in.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/rangebin_fifo_in.sv
`default_nettype none
// ============================================================================
// Module  : rangebin_fifo_in
// Purpose : Trigger-windowed ADC word capture into a RAM, replayed as
//           zero-padded NFFT-sample frames. Macro RANGEBIN_INDEX_EN adds bin_index.
// Rev     : 1.0
// ============================================================================
module rangebin_fifo_in #(
    parameter int DW     = 14,
    parameter int LANES  = 2,
    parameter int NFFT   = 1024,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW*LANES-1:0]   data_in,
    input  logic                  start,
    input  logic [CNT_W-1:0]      total_words,
    input  logic [CNT_W-1:0]      skip_begin,
    input  logic [CNT_W-1:0]      skip_end,
    input  logic [CNT_W-1:0]      bin_len,
    output logic [DW-1:0]         data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sop,
    output logic                  eop,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef RANGEBIN_INDEX_EN
    ,
    output logic [CNT_W-1:0]      bin_index
`endif
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int LANE_SH = $clog2(LANES);
    localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  C_NFFT      = CNT_W'(NFFT);
    localparam logic [CNT_W-1:0]  C_NFFT_M1   = CNT_W'(NFFT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PAD    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    total_q, total_d, skip_b_q, skip_b_d, skip_e_q, skip_e_d;
    logic [CNT_W-1:0]    bin_len_q, bin_len_d, w_q, w_d;
    logic                wr_active_q, wr_active_d, overflow_q, overflow_d;
    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW*LANES-1:0] rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [CNT_W-1:0]    issued_q, issued_d, load_cnt_q, load_cnt_d, acc_cnt_q, acc_cnt_d;
    logic [DW-1:0]       data_out_q, data_out_d;
    logic                out_valid_q, out_valid_d, sop_q, sop_d, eop_q, eop_d, done_q, done_d;

    logic [DW*LANES-1:0] mem [0:DEPTH-1];
    logic [DW-1:0]       lane_arr [0:(1<<LANE_W)-1];

    logic              start_acc, keep, we, full, go, rd_en, accept, ld;
    logic              in_frame, want_data, want_pad, take, load, last_lane;
    logic [ADDR_W:0]   occ;
    logic [CNT_W-1:0]  bin_words;

    for (genvar g = 0; g < (1 << LANE_W); g++) begin : g_lane
        if (g < LANES) begin : g_real
            assign lane_arr[g] = rd_data_q[g*DW +: DW];
        end else begin : g_unused
            assign lane_arr[g] = '0;
        end
    end

    assign start_acc = start && (state_q == S_IDLE);
    assign occ       = wr_ptr_q - rd_ptr_q;
    assign full      = occ[ADDR_W];
    assign bin_words = bin_len_q >> LANE_SH;
    assign keep      = !((w_q >= skip_b_q) && (w_q < skip_e_q));
    assign we        = wr_active_q && keep && !full;
    assign go        = CNT_W'(occ) >= bin_words;
    assign accept    = out_valid_q && out_ready;
    assign ld        = !out_valid_q || out_ready;
    assign in_frame  = (state_q == S_DATA) || (state_q == S_PAD);
    assign want_data = in_frame && (load_cnt_q < bin_len_q);
    assign want_pad  = in_frame && !(load_cnt_q < bin_len_q) && (load_cnt_q < C_NFFT);
    assign last_lane = (lane_q == C_LAST_LANE);
    assign take      = ld && want_data && rd_vld_q;
    assign load      = take || (ld && want_pad);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state (frame transitions follow accepted beats)
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_acc) state_d = S_WAIT;
            S_WAIT:   if (go) state_d = S_DATA;
                      else if (!wr_active_q) state_d = S_FINISH;
            S_DATA:   if (accept && (acc_cnt_q == bin_len_q - CNT_W'(1)))
                          state_d = (bin_len_q == C_NFFT) ? S_WAIT : S_PAD;
            S_PAD:    if (accept && (acc_cnt_q == C_NFFT_M1)) state_d = S_WAIT;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; the first word of a bin is fetched on the WAIT->DATA edge
    always_comb begin
        busy  = (state_q != S_IDLE);
        rd_en = 1'b0;
        if (state_q == S_WAIT)
            rd_en = go;
        else if (state_q == S_DATA)
            rd_en = (issued_q < bin_words) && (occ != '0) && (!rd_vld_q || (take && last_lane));
    end

    always_comb begin
        total_d     = total_q;
        skip_b_d    = skip_b_q;
        skip_e_d    = skip_e_q;
        bin_len_d   = bin_len_q;
        wr_active_d = wr_active_q;
        w_d         = w_q;
        overflow_d  = overflow_q;
        if (start_acc) begin
            total_d     = total_words;
            skip_b_d    = skip_begin;
            skip_e_d    = skip_end;
            bin_len_d   = bin_len;
            wr_active_d = (total_words != '0);
            w_d         = '0;
            overflow_d  = 1'b0;
        end else if (wr_active_q) begin
            w_d = w_q + CNT_W'(1);
            if (w_q == total_q - CNT_W'(1)) wr_active_d = 1'b0;
            if (keep && full) overflow_d = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(we);
        rd_ptr_d = (state_q == S_FINISH) ? wr_ptr_q : rd_ptr_q + (ADDR_W+1)'(rd_en);
    end

    // Read pipeline: RAM word register, lane serialiser, output register
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en)
            rd_data_d = (we && (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]))
                      ? data_in : mem[rd_ptr_q[ADDR_W-1:0]];
        rd_vld_d   = rd_en ? 1'b1 : ((take && last_lane) ? 1'b0 : rd_vld_q);
        lane_d     = take ? (last_lane ? '0 : lane_q + LANE_W'(1)) : lane_q;
        issued_d   = issued_q + CNT_W'(rd_en);
        load_cnt_d = load_cnt_q + CNT_W'(load);
        acc_cnt_d  = acc_cnt_q + CNT_W'(accept);
        if (!in_frame) begin
            lane_d     = '0;
            issued_d   = CNT_W'(rd_en);
            load_cnt_d = '0;
            acc_cnt_d  = '0;
        end
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        if (load) begin
            data_out_d  = take ? lane_arr[lane_q] : '0;
            out_valid_d = 1'b1;
            sop_d       = (load_cnt_q == '0);
            eop_d       = (load_cnt_q == C_NFFT_M1);
        end else if (ld) begin
            out_valid_d = 1'b0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
        end
        done_d = (state_q == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q     <= '0;  skip_b_q   <= '0;  skip_e_q  <= '0;  bin_len_q <= '0;
            wr_active_q <= 1'b0; w_q       <= '0;  overflow_q <= 1'b0;
            wr_ptr_q    <= '0;  rd_ptr_q   <= '0;  rd_data_q <= '0;  rd_vld_q  <= 1'b0;
            lane_q      <= '0;  issued_q   <= '0;  load_cnt_q <= '0; acc_cnt_q <= '0;
            data_out_q  <= '0;  out_valid_q <= 1'b0; sop_q   <= 1'b0; eop_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            total_q     <= total_d;   skip_b_q   <= skip_b_d;  skip_e_q   <= skip_e_d;
            bin_len_q   <= bin_len_d; wr_active_q <= wr_active_d; w_q     <= w_d;
            overflow_q  <= overflow_d; wr_ptr_q  <= wr_ptr_d;  rd_ptr_q   <= rd_ptr_d;
            rd_data_q   <= rd_data_d; rd_vld_q   <= rd_vld_d;  lane_q     <= lane_d;
            issued_q    <= issued_d;  load_cnt_q <= load_cnt_d; acc_cnt_q <= acc_cnt_d;
            data_out_q  <= data_out_d; out_valid_q <= out_valid_d;
            sop_q       <= sop_d;     eop_q      <= eop_d;     done_q     <= done_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign sop       = sop_q;
    assign eop       = eop_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

`ifdef RANGEBIN_INDEX_EN
    logic [CNT_W-1:0] bin_idx_q, bin_idx_d;

    always_comb begin
        bin_idx_d = bin_idx_q;
        if (start_acc)            bin_idx_d = '0;
        else if (accept && eop_q) bin_idx_d = bin_idx_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bin_idx_q <= '0;
        else     bin_idx_q <= bin_idx_d;
    end

    assign bin_index = bin_idx_q;
`endif

endmodule
`default_nettype wire
